// File: rtl/jtkcpu_div.sv
// Multi-cycle restoring divider: 16/8 or 8/8, signed or unsigned, one quotient
// bit per enabled clock, producing an 8-bit quotient, 8-bit remainder and overflow flag.
module jtkcpu_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [15:0] op0,
    input  logic [7:0]  op1,
    input  logic        len,
    input  logic        sign,
    input  logic        start,
    output logic [7:0]  quot,
    output logic [7:0]  rem,
    output logic        busy,
    output logic        v
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINAL} state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;      // dividend shifts out the top, quotient bits enter the bottom
    logic [7:0]  prem_q, prem_d;
    logic [7:0]  dsr_q, dsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic        nq_q, nq_d;
    logic        nr_q, nr_d;
    logic [7:0]  raw_q, raw_d;
    logic [7:0]  quot_q, quot_d;
    logic [7:0]  rem_q, rem_d;
    logic        v_q, v_d;

    logic [15:0] dvd_ext, dvd_mag;
    logic [7:0]  dsr_mag;
    logic        dvd_neg, dsr_neg;
    logic [8:0]  trial;
    logic        take;
    logic [7:0]  diff;
    logic [7:0]  qs, rs;
    logic        ovf, dz;

    always_comb begin
        dvd_ext = len ? op0 : (sign ? {{8{op0[7]}}, op0[7:0]} : {8'h00, op0[7:0]});
        dvd_neg = sign & dvd_ext[15];
        dsr_neg = sign & op1[7];
        dvd_mag = dvd_neg ? (~dvd_ext + 16'd1) : dvd_ext;
        dsr_mag = dsr_neg ? (~op1 + 8'd1) : op1;

        trial = {prem_q, dvd_q[15]};
        take  = trial >= {1'b0, dsr_q};
        diff  = trial[7:0] - dsr_q;

        dz  = (dsr_q == 8'd0);
        qs  = nq_q ? (~dvd_q[7:0] + 8'd1) : dvd_q[7:0];
        rs  = nr_q ? (~prem_q + 8'd1) : prem_q;
        // A negative quotient may reach -128, one step further than a positive one.
        if (dz)
            ovf = 1'b1;
        else if (sgn_q)
            ovf = nq_q ? (dvd_q > 16'd128) : (dvd_q > 16'd127);
        else
            ovf = dvd_q > 16'd255;
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        prem_d  = prem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        raw_d   = raw_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // 8-bit dividends are pre-aligned so the same MSB-first loop serves both lengths.
                    dvd_d   = len ? dvd_mag : {dvd_mag[7:0], 8'h00};
                    prem_d  = 8'd0;
                    dsr_d   = dsr_mag;
                    cnt_d   = len ? 5'd16 : 5'd8;
                    sgn_d   = sign;
                    nq_d    = dvd_neg ^ dsr_neg;
                    nr_d    = dvd_neg;
                    raw_d   = op0[7:0];
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                prem_d = take ? diff : trial[7:0];
                dvd_d  = {dvd_q[14:0], take};
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1)
                    state_d = S_FINAL;
            end
            S_FINAL: begin
                quot_d  = dz ? 8'hFF : qs;
                rem_d   = dz ? raw_q : rs;
                v_d     = ovf;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= 16'd0;
            prem_q  <= 8'd0;
            dsr_q   <= 8'd0;
            cnt_q   <= 5'd0;
            sgn_q   <= 1'b0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            raw_q   <= 8'd0;
            quot_q  <= 8'd0;
            rem_q   <= 8'd0;
            v_q     <= 1'b0;
        end else if (cen) begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            prem_q  <= prem_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            raw_q   <= raw_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            v_q     <= v_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign quot = quot_q;
    assign rem  = rem_q;
    assign v    = v_q;
endmodule

// File: tb/tb_jtkcpu_div.sv
// Self-checking bench for jtkcpu_div: directed cases, randomized unsigned and
// signed regressions against an arithmetic reference model, cen toggling and mid-run reset.
module tb_jtkcpu_div;
    logic        clk = 1'b0;
    logic        rst, cen, len, sign, start;
    logic [15:0] op0;
    logic [7:0]  op1;
    logic [7:0]  quot, rem;
    logic        busy, v;

    int checks   = 0;
    int failures = 0;

    jtkcpu_div dut (
        .clk(clk), .rst(rst), .cen(cen), .op0(op0), .op1(op1), .len(len),
        .sign(sign), .start(start), .quot(quot), .rem(rem), .busy(busy), .v(v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on the formed operands.
    task automatic model(input logic [15:0] a0, input logic [7:0] b0, input logic l, input logic s,
                         output logic [7:0] eq, output logic [7:0] er, output logic ev);
        int a, b, q, r;
        logic [7:0] lo;
        lo = a0[7:0];
        if (s) begin
            a = l ? int'($signed(a0)) : int'($signed(lo));
            b = int'($signed(b0));
        end else begin
            a = l ? int'(a0) : int'(lo);
            b = int'(b0);
        end
        if (b == 0) begin
            ev = 1'b1; eq = 8'hFF; er = a[7:0];
        end else begin
            q  = a / b;
            r  = a % b;
            ev = s ? (q < -128 || q > 127) : (q > 255);
            eq = q[7:0];
            er = r[7:0];
        end
    endtask

    task automatic do_div(input logic [15:0] a, input logic [7:0] b, input logic l, input logic s,
                          input int hold, input bit rnd_cen, input bit verbose);
        logic [7:0] eq, er;
        logic ev, was_busy, c;
        int lat, n, k;
        model(a, b, l, s, eq, er, ev);
        @(negedge clk);
        op0 = a; op1 = b; len = l; sign = s; start = 1'b1; cen = 1'b1;
        @(posedge clk); #1;
        check("accept_busy", busy, 1);
        lat = 0; n = 0; k = 1;
        while (1) begin
            @(negedge clk);
            if (k >= hold) start = 1'b0;
            else begin
                op0 = 16'($urandom); op1 = 8'($urandom); len = 1'($urandom); sign = 1'($urandom);
            end
            k++;
            cen = rnd_cen ? 1'($urandom_range(0, 1)) : 1'b1;
            was_busy = busy; c = cen;
            @(posedge clk); #1;
            if (was_busy && c) lat++;
            if (!busy) break;
            n++;
            if (n > 400) begin
                check("busy_timeout", 1, 0);
                break;
            end
        end
        start = 1'b0;
        check("latency", lat, l ? 17 : 9);
        check("quot", quot, eq);
        check("rem", rem, er);
        check("v", v, ev);
        @(negedge clk); cen = 1'b1;
        @(posedge clk); #1;
        check("single_start", busy, 0);
        if (verbose)
            $display("div op0=%h op1=%h len=%0d sign=%0d -> quot=%h rem=%h v=%0d lat=%0d",
                     a, b, l, s, quot, rem, v, lat);
    endtask

    initial begin
        logic [15:0] a;
        rst = 1'b1; cen = 1'b1; start = 1'b0; len = 1'b0; sign = 1'b0; op0 = '0; op1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_quot", quot, 0);
        check("rst_rem", rem, 0);
        check("rst_v", v, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); rst = 1'b0;

        // Directed cases; the expectations below are also re-checked literally.
        do_div(16'd125, 8'd7, 1'b0, 1'b0, 3, 1'b0, 1'b1);
        check("dir_125_7_q", quot, 17); check("dir_125_7_r", rem, 6);
        do_div(16'h1234, 8'h56, 1'b1, 1'b0, 3, 1'b0, 1'b1);
        check("dir_1234_q", quot, 54); check("dir_1234_r", rem, 16);
        do_div(16'h8000, 8'h10, 1'b1, 1'b0, 1, 1'b0, 1'b1);
        check("dir_ovf_v", v, 1);
        do_div(16'd50, 8'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        check("dir_dz_v", v, 1); check("dir_dz_q", quot, 8'hFF); check("dir_dz_r", rem, 50);
        do_div(16'h00F9, 8'd2, 1'b0, 1'b1, 2, 1'b0, 1'b1);
        check("dir_sgn_q", quot, 8'hFD); check("dir_sgn_r", rem, 8'hFF); check("dir_sgn_v", v, 0);
        do_div(16'h8000, 8'hFF, 1'b1, 1'b1, 1, 1'b0, 1'b1);
        do_div(16'h0080, 8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b1);
        do_div(16'hFF80, 8'h01, 1'b1, 1'b1, 1, 1'b0, 1'b1);
        do_div(16'h0064, 8'h80, 1'b0, 1'b1, 1, 1'b0, 1'b1);

        // Unsigned regression.
        for (int i = 0; i < 2048; i++) begin
            logic l;
            l = 1'($urandom);
            a = l ? 16'($urandom) : {8'h00, 8'($urandom)};
            do_div(a, 8'($urandom), l, 1'b0, 1, 1'b0, 1'b0);
        end

        // Signed regression with start held and cen toggling.
        for (int i = 0; i < 300; i++) begin
            do_div(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(1, 3), 1'b1, 1'b0);
        end

        // Reset mid-division aborts and clears outputs.
        do_div(16'd200, 8'd3, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        @(negedge clk);
        op0 = 16'hABCD; op1 = 8'd9; len = 1'b1; sign = 1'b0; start = 1'b1; cen = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_quot", quot, 0);
        check("midrst_rem", rem, 0);
        check("midrst_v", v, 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_idle", busy, 0);
        do_div(16'hABCD, 8'd9, 1'b1, 1'b0, 1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
